// File: rtl/exception_unit.sv
// MEM-stage exception/interrupt resolver and CP0 register file.
// Redirect outputs are combinational; CP0 state updates on the following edge.
module exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_InDelaySlot,
    input  logic [5:0]  MEM_Except,
    input  logic        MEM_IsStore,
    input  logic [31:0] MEM_BadVAddr,
    input  logic        MEM_IsEret,
    input  logic        MEM_CP0Wr,
    input  logic [4:0]  MEM_CP0Addr,
    input  logic [31:0] MEM_CP0WrData,
    output logic [31:0] CP0RdData,
    input  logic [5:0]  Ext_Int,
    output logic [31:0] IF_NPC,
    output logic        IF_PCWr,
    output logic        Flush,
    output logic [31:0] Status_o,
    output logic [31:0] Cause_o,
    output logic [31:0] EPC_o
);

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_e;

    localparam logic [4:0]  A_BADVADDR   = 5'd8;
    localparam logic [4:0]  A_COUNT      = 5'd9;
    localparam logic [4:0]  A_COMPARE    = 5'd11;
    localparam logic [4:0]  A_STATUS     = 5'd12;
    localparam logic [4:0]  A_CAUSE      = 5'd13;
    localparam logic [4:0]  A_EPC        = 5'd14;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] status_q, status_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic [7:0]  ip_q, ip_d;
    logic        bd_q, bd_d, ti_q, ti_d, tick_q;
    exc_code_e   exccode_q, exccode_d;

    logic        int_pending, exc_taken, eret_taken, cp0_we;
    exc_code_e   exc_code;
    logic        bad_we;
    logic [31:0] bad_val, cause;

    assign cause = {bd_q, ti_q, 14'b0, ip_q, 1'b0, exccode_q, 2'b0};

    assign int_pending = status_q[0] & ~status_q[1] & (|(ip_q & status_q[15:8])) & MEM_Valid;
    assign exc_taken   = MEM_Valid & (int_pending | (|MEM_Except));
    assign eret_taken  = MEM_Valid & MEM_IsEret & ~exc_taken;
    assign cp0_we      = MEM_CP0Wr & MEM_Valid & ~exc_taken & ~eret_taken;

    always_comb begin
        exc_code = EXC_INT;
        bad_we   = 1'b0;
        bad_val  = '0;
        if (int_pending) begin
            exc_code = EXC_INT;
        end else if (MEM_Except[5]) begin
            exc_code = EXC_ADEL;
            bad_we   = 1'b1;
            bad_val  = MEM_PC;
        end else if (MEM_Except[4]) begin
            exc_code = EXC_RI;
        end else if (MEM_Except[3]) begin
            exc_code = EXC_OV;
        end else if (MEM_Except[2]) begin
            exc_code = EXC_SYS;
        end else if (MEM_Except[1]) begin
            exc_code = EXC_BP;
        end else if (MEM_Except[0]) begin
            exc_code = MEM_IsStore ? EXC_ADES : EXC_ADEL;
            bad_we   = 1'b1;
            bad_val  = MEM_BadVAddr;
        end
    end

    assign Flush   = exc_taken | eret_taken;
    assign IF_PCWr = exc_taken | eret_taken;
    assign IF_NPC  = exc_taken ? EXC_VECTOR : (eret_taken ? epc_q : '0);

    always_comb begin
        case (MEM_CP0Addr)
            A_BADVADDR: CP0RdData = badvaddr_q;
            A_COUNT:    CP0RdData = count_q;
            A_COMPARE:  CP0RdData = compare_q;
            A_STATUS:   CP0RdData = status_q;
            A_CAUSE:    CP0RdData = cause;
            A_EPC:      CP0RdData = epc_q;
            default:    CP0RdData = '0;
        endcase
    end

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        count_d    = tick_q ? count_q + 32'd1 : count_q;
        ti_d       = ti_q | (count_q == compare_q);
        // IP[7:2] samples the lines using the already-registered TI
        ip_d       = {Ext_Int[5] | ti_q, Ext_Int[4:0], ip_q[1:0]};
        if (cp0_we) begin
            case (MEM_CP0Addr)
                A_COUNT:   count_d = MEM_CP0WrData;
                A_COMPARE: begin
                    compare_d = MEM_CP0WrData;
                    ti_d      = 1'b0;
                end
                A_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (MEM_CP0WrData & STATUS_WMASK);
                A_CAUSE:   ip_d[1:0] = MEM_CP0WrData[9:8];
                A_EPC:     epc_d = MEM_CP0WrData;
                default:   ;
            endcase
        end
        if (exc_taken) begin
            exccode_d   = exc_code;
            status_d[1] = 1'b1;
            if (!status_q[1]) begin
                epc_d = MEM_InDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
                bd_d  = MEM_InDelaySlot;
            end
            if (bad_we) badvaddr_d = bad_val;
        end else if (eret_taken) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= STATUS_RESET;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            ip_q       <= '0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            tick_q     <= 1'b0;
            exccode_q  <= EXC_INT;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            ip_q       <= ip_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            tick_q     <= ~tick_q;
            exccode_q  <= exccode_d;
        end
    end

    assign Status_o = status_q;
    assign Cause_o  = cause;
    assign EPC_o    = epc_q;

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed test-plan steps, then random traffic,
// all checked against a word-level CP0 reference model.
module tb_exception_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_Valid, MEM_InDelaySlot, MEM_IsStore, MEM_IsEret, MEM_CP0Wr;
    logic [31:0] MEM_PC, MEM_BadVAddr, MEM_CP0WrData;
    logic [5:0]  MEM_Except, Ext_Int;
    logic [4:0]  MEM_CP0Addr;
    logic [31:0] CP0RdData, IF_NPC, Status_o, Cause_o, EPC_o;
    logic        IF_PCWr, Flush;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare;
    logic        m_tick;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam logic [31:0] SRST = 32'h0040_0000;

    exception_unit #(.EXC_VECTOR(VEC), .STATUS_RESET(SRST)) dut (
        .clk(clk), .rst(rst), .MEM_Valid(MEM_Valid), .MEM_PC(MEM_PC),
        .MEM_InDelaySlot(MEM_InDelaySlot), .MEM_Except(MEM_Except),
        .MEM_IsStore(MEM_IsStore), .MEM_BadVAddr(MEM_BadVAddr),
        .MEM_IsEret(MEM_IsEret), .MEM_CP0Wr(MEM_CP0Wr), .MEM_CP0Addr(MEM_CP0Addr),
        .MEM_CP0WrData(MEM_CP0WrData), .CP0RdData(CP0RdData), .Ext_Int(Ext_Int),
        .IF_NPC(IF_NPC), .IF_PCWr(IF_PCWr), .Flush(Flush),
        .Status_o(Status_o), .Cause_o(Cause_o), .EPC_o(EPC_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_status = SRST; m_cause = '0; m_epc = '0; m_bad = '0;
        m_count = '0; m_compare = '0; m_tick = 1'b0;
    endtask

    function automatic logic [4:0] code_of(input int b);
        case (b)
            5: return 5'h04;
            4: return 5'h0A;
            3: return 5'h0C;
            2: return 5'h08;
            1: return 5'h09;
            default: return MEM_IsStore ? 5'h05 : 5'h04;
        endcase
    endfunction

    task automatic model_comb(output logic [31:0] npc, output logic redirect,
                              output logic [31:0] rd, output logic tk, output logic er,
                              output logic [4:0] code, output int src);
        logic irq;
        irq = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h00) && MEM_Valid;
        src = -1;
        if (!irq)
            for (int i = 5; i >= 0; i--)
                if (MEM_Except[i] && src < 0) src = i;
        code = (irq || src < 0) ? 5'h00 : code_of(src);
        tk = MEM_Valid && (irq || src >= 0);
        er = MEM_Valid && MEM_IsEret && !tk;
        npc = tk ? VEC : (er ? m_epc : 32'h0);
        redirect = tk || er;
        case (MEM_CP0Addr)
            5'd8:  rd = m_bad;
            5'd9:  rd = m_count;
            5'd11: rd = m_compare;
            5'd12: rd = m_status;
            5'd13: rd = m_cause;
            5'd14: rd = m_epc;
            default: rd = 32'h0;
        endcase
    endtask

    task automatic model_update(input logic tk, input logic er, input logic [4:0] code, input int src);
        logic [31:0] s, c, e, b, cnt, cmp;
        logic we;
        we  = MEM_CP0Wr && MEM_Valid && !tk && !er;
        s = m_status; c = m_cause; e = m_epc; b = m_bad; cmp = m_compare;
        cnt = m_tick ? m_count + 32'd1 : m_count;
        if (m_count == m_compare) c[30] = 1'b1;
        c[15:10] = {Ext_Int[5] | m_cause[30], Ext_Int[4:0]};
        if (we) begin
            case (MEM_CP0Addr)
                5'd9:  cnt = MEM_CP0WrData;
                5'd11: begin cmp = MEM_CP0WrData; c[30] = 1'b0; end
                5'd12: s = (s & ~32'h0000_FF03) | (MEM_CP0WrData & 32'h0000_FF03);
                5'd13: c[9:8] = MEM_CP0WrData[9:8];
                5'd14: e = MEM_CP0WrData;
                default: ;
            endcase
        end
        if (tk) begin
            c[6:2] = code;
            if (!m_status[1]) begin
                e = MEM_InDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
                c[31] = MEM_InDelaySlot;
            end
            s[1] = 1'b1;
            if (src == 5) b = MEM_PC;
            else if (src == 0) b = MEM_BadVAddr;
        end else if (er) begin
            s[1] = 1'b0;
        end
        m_status = s; m_cause = c; m_epc = e; m_bad = b;
        m_count = cnt; m_compare = cmp; m_tick = !m_tick;
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic step();
        logic [31:0] npc, rd;
        logic redirect, tk, er;
        logic [4:0] code;
        int src;
        #1;
        model_comb(npc, redirect, rd, tk, er, code, src);
        chk("IF_NPC", IF_NPC, npc);
        chk("IF_PCWr", {31'b0, IF_PCWr}, {31'b0, redirect});
        chk("Flush", {31'b0, Flush}, {31'b0, redirect});
        chk("CP0RdData", CP0RdData, rd);
        @(posedge clk);
        model_update(tk, er, code, src);
        #1;
        chk("Status", Status_o, m_status);
        chk("Cause", Cause_o, m_cause);
        chk("EPC", EPC_o, m_epc);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ds, input logic [5:0] ex,
                         input logic st, input logic [31:0] bad, input logic er,
                         input logic wr, input logic [4:0] addr, input logic [31:0] wd);
        MEM_Valid = v; MEM_PC = pc; MEM_InDelaySlot = ds; MEM_Except = ex;
        MEM_IsStore = st; MEM_BadVAddr = bad; MEM_IsEret = er;
        MEM_CP0Wr = wr; MEM_CP0Addr = addr; MEM_CP0WrData = wd;
    endtask

    task automatic idle(input logic [4:0] addr);
        drive(1'b1, 32'h8000_0100, 1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, addr, 32'h0);
    endtask

    initial begin
        logic [4:0] addrs [8];
        logic found;
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};
        rst = 1'b1;
        Ext_Int = 6'b0;
        idle(5'd12);
        model_reset();
        #3;
        chk("reset_status", Status_o, SRST);
        chk("reset_cause", Cause_o, 32'h0);
        chk("reset_epc", EPC_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Reserved instruction in a delay slot
        drive(1'b1, 32'h8000_1000, 1'b1, 6'b010000, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("ri_npc", IF_NPC, VEC);
        chk("ri_flush", {31'b0, Flush}, 32'd1);
        step();
        chk("ri_epc", EPC_o, 32'h8000_0FFC);
        chk("ri_bd", {31'b0, Cause_o[31]}, 32'd1);
        chk("ri_code", {27'b0, Cause_o[6:2]}, 32'h0A);
        chk("ri_exl", {31'b0, Status_o[1]}, 32'd1);

        // IF address fault outranks MEM address fault
        drive(1'b1, 32'h8000_3000, 1'b0, 6'b100001, 1'b0, 32'h1234, 1'b0, 1'b0, 5'd8, 32'h0);
        step();
        idle(5'd8);
        #1;
        chk("adif_badvaddr", CP0RdData, 32'h8000_3000);
        chk("adif_code", {27'b0, Cause_o[6:2]}, 32'h04);
        step();

        // Eret to a written EPC, then eret colliding with overflow
        drive(1'b1, 32'h8000_0200, 1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd14, 32'h8000_2000);
        step();
        drive(1'b1, 32'h8000_0204, 1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        #1;
        chk("eret_npc", IF_NPC, 32'h8000_2000);
        chk("eret_pcwr", {31'b0, IF_PCWr}, 32'd1);
        step();
        chk("eret_exl", {31'b0, Status_o[1]}, 32'd0);
        drive(1'b1, 32'h8000_4000, 1'b0, 6'b001000, 1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        #1;
        chk("eret_ov_npc", IF_NPC, VEC);
        step();
        chk("eret_ov_code", {27'b0, Cause_o[6:2]}, 32'h0C);
        chk("eret_ov_epc", EPC_o, 32'h8000_4000);

        // External interrupt on HW0 with IE=1, IM2=1
        drive(1'b1, 32'h8000_0300, 1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0000_0401);
        step();
        chk("int_status", Status_o, 32'h0040_0401);
        idle(5'd13);
        Ext_Int = 6'b000001;
        #1;
        chk("int_not_yet", {31'b0, Flush}, 32'd0);
        step();
        #1;
        chk("int_taken", {31'b0, Flush}, 32'd1);
        step();
        chk("int_code", {27'b0, Cause_o[6:2]}, 32'h00);
        chk("int_exl", {31'b0, Status_o[1]}, 32'd1);
        #1;
        chk("int_masked_by_exl", {31'b0, Flush}, 32'd0);
        step();
        Ext_Int = 6'b0;
        step();

        // Timer: Count=0, Compare=10, wait for TI then IP7
        drive(1'b1, 32'h8000_0400, 1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd9, 32'h0);
        step();
        drive(1'b1, 32'h8000_0404, 1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd11, 32'd10);
        step();
        chk("ti_cleared", {31'b0, Cause_o[30]}, 32'd0);
        idle(5'd9);
        found = Cause_o[30];
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = Cause_o[30];
        end
        chk("ti_set", {31'b0, found}, 32'd1);
        step();
        chk("ti_ip7", {31'b0, Cause_o[15]}, 32'd1);

        // mtc0 Compare alongside syscall is suppressed
        drive(1'b1, 32'h8000_0500, 1'b0, 6'b000100, 1'b0, 32'h0, 1'b0, 1'b1, 5'd11, 32'h55);
        step();
        idle(5'd11);
        #1;
        chk("sys_mtc0_suppressed", CP0RdData, 32'd10);
        chk("sys_ti_kept", {31'b0, Cause_o[30]}, 32'd1);
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, 1'(($urandom_range(0, 1))),
                  ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'b0, 1'($urandom_range(0, 1)),
                  $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                  addrs[$urandom_range(0, 7)], $urandom);
            if ($urandom_range(0, 7) == 0) Ext_Int = 6'($urandom);
            step();
        end

        // Asynchronous reset mid-run
        idle(5'd9);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_status", Status_o, SRST);
        chk("arst_cause", Cause_o, 32'h0);
        chk("arst_epc", EPC_o, 32'h0);
        chk("arst_count", CP0RdData, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        Ext_Int = 6'b0;
        for (int i = 0; i < 4; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
